flag_register: RTL
==================

# flag_register

Condition-code register for the execute stage. Latches the Z/N/C flags produced by the ALU at the clock edge, applying per-instruction update masks and SETC/CLRC. Resolves conditional jumps (JZ/JN/JC) against the committed flags and clears the tested flag on a taken jump. Keeps a small flag stack so interrupt entry and RTI can save and restore the flags.

## Interface
- DEPTH, 2, number of entries in the flag stack (≥1)
- CNT_W, 2, width of the stack count; must hold values 0..DEPTH
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  stage enable; 0 = stall, all state held and branch_taken forced 0
- alu_flags  in  3  ALU flag outputs: [0]=Z, [1]=N, [2]=C
- upd_z, upd_n, upd_c  in  1 each  per-flag write enables from the decoded opcode
- set_c, clr_c  in  1 each  SETC/CLRC; override upd_c
- jmp_valid  in  1  conditional jump present this cycle
- jmp_type  in  2  01=JZ, 10=JN, 11=JC, 00=none (never taken)
- int_save  in  1  push the current ccr onto the flag stack
- rti_restore  in  1  pop the flag stack into ccr
- ccr  out  3  committed flags, same bit order as alu_flags
- branch_taken  out  1  combinational jump decision
- stack_count  out  CNT_W  number of occupied stack entries
- ovf  out  1  sticky: a push was attempted while the stack was full
- unf  out  1  sticky: a pop was attempted while the stack was empty

## Operation
- Reset values (rst high at the edge): ccr=000, stack_count=0, ovf=0, unf=0, all stack entries 000. branch_taken is 0 while rst is high.
- rst has priority over everything. When en=0 (and no reset), nothing changes.
- branch_taken = en & !rst & jmp_valid & (JZ: ccr[0], JN: ccr[1], JC: ccr[2]). It uses the registered ccr, not alu_flags. Hazards between the ALU and the branch are resolved outside this block.
- Next-ccr calculation, applied in this order:
  1. Per-flag merge. Z takes alu_flags[0] if upd_z, otherwise keeps its value. N does the same with upd_n.
  2. C: set_c gives 1. Otherwise clr_c gives 0. Otherwise C follows upd_c (alu_flags[2] or hold). If set_c and clr_c are both high, set_c wins.
  3. If branch_taken, the flag that was tested is cleared in the merged value. The clear beats an ALU write to the same flag in the same cycle.
  4. If rti_restore and stack_count>0, ccr takes the top entry, replacing steps 1-3 entirely.
- Push (int_save only):
  - count<DEPTH: write the current registered ccr (the pre-update value) into slot count, then count+1.
  - count==DEPTH: the stack is unchanged and ovf is set.
  - ccr still updates normally through steps 1-3.
- Pop (rti_restore only):
  - count>0: ccr takes slot count-1, then count-1.
  - count==0: ccr updates normally through steps 1-3, count stays 0, and unf is set.
- int_save and rti_restore together:
  - count>0: swap. ccr takes the top entry, the top entry takes the old ccr, count is unchanged.
  - count==0: behaves as a plain push and unf is set.
- ovf and unf clear only on reset.

## Timing
- Flag latency: alu_flags presented in cycle N appear on ccr after the rising edge that ends cycle N. An instruction in cycle N+1 sees them.
- branch_taken depends only on inputs and state in the same cycle and has no registered delay. Its clear-on-taken effect lands on the same edge as the flag update.
- Stack push, pop and swap each complete in one cycle. Back-to-back push/pop on consecutive cycles is supported at full rate.
- Reset in the middle of an operation wins at the edge. Any push, pop or flag update in that cycle is discarded.

## Test plan
- Reset, then an ADD cycle with alu_flags=101 and upd_z=upd_n=upd_c=1 -> ccr=101 one edge later. The next cycle with all upd_*=0 holds ccr at 101.
- ccr=001, JZ with jmp_valid=1 -> branch_taken=1 in the same cycle and ccr=000 after the edge. Repeat with ccr=000 -> branch_taken=0 and ccr unchanged.
- set_c=clr_c=1 with ccr=000 -> ccr=100. Then en=0 with upd_*=1 and alu_flags=011 -> ccr stays 100 and branch_taken=0.
- DEPTH=2, ccr=011:
  - int_save gives count=1.
  - Set ccr to 100 and int_save again: count=2.
  - A third int_save gives ovf=1 and count=2.
  - rti_restore gives ccr=100 and count=1. rti_restore again gives ccr=011 and count=0.
  - A third rti_restore gives unf=1 and ccr unchanged.
- Simultaneous int_save and rti_restore with count=1, stack top=010, ccr=101 -> ccr=010, top=101, count=1.
- Assert rst in the same cycle as int_save and a taken JC -> ccr=000, count=0, ovf=unf=0 after the edge, and branch_taken=0 during that cycle.

Source files
------------

// File: rtl/flag_register_if.sv
// Flag register bus: ALU flags, update controls, jump request and stack controls in,
// committed flags, jump decision and stack status out.
interface flag_register_if #(
  parameter int CNT_W = 2
);
  logic             en;
  logic [2:0]       alu_flags;
  logic             upd_z;
  logic             upd_n;
  logic             upd_c;
  logic             set_c;
  logic             clr_c;
  logic             jmp_valid;
  logic [1:0]       jmp_type;
  logic             int_save;
  logic             rti_restore;
  logic [2:0]       ccr;
  logic             branch_taken;
  logic [CNT_W-1:0] stack_count;
  logic             ovf;
  logic             unf;

  modport master (
    output en, alu_flags, upd_z, upd_n, upd_c, set_c, clr_c,
           jmp_valid, jmp_type, int_save, rti_restore,
    input  ccr, branch_taken, stack_count, ovf, unf
  );

  modport slave (
    input  en, alu_flags, upd_z, upd_n, upd_c, set_c, clr_c,
           jmp_valid, jmp_type, int_save, rti_restore,
    output ccr, branch_taken, stack_count, ovf, unf
  );
endinterface

// File: rtl/flag_register.sv
// Z/N/C condition-code register with masked ALU updates, SETC/CLRC, jump resolution
// with clear-on-taken, and a small save/restore stack for interrupt entry and RTI.
module flag_register #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input logic            clk,
  input logic            rst,
  flag_register_if.slave bus
);
  logic [2:0]       ccr_q, ccr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [2:0]       stack_q [DEPTH];

  logic             taken;
  logic [2:0]       merged;
  logic [2:0]       top_entry;
  logic             stk_empty, stk_full;
  logic             swap_go, push_go, pop_go;
  logic [CNT_W-1:0] wr_idx;
  logic [DEPTH-1:0] slot_wr;

  // Jump decision looks only at committed flags, never at this cycle's ALU result.
  always_comb begin
    taken = 1'b0;
    if (bus.en && !rst && bus.jmp_valid) begin
      case (bus.jmp_type)
        2'b01:   taken = ccr_q[0];
        2'b10:   taken = ccr_q[1];
        2'b11:   taken = ccr_q[2];
        default: taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    merged[0] = bus.upd_z ? bus.alu_flags[0] : ccr_q[0];
    merged[1] = bus.upd_n ? bus.alu_flags[1] : ccr_q[1];
    if (bus.set_c)      merged[2] = 1'b1;
    else if (bus.clr_c) merged[2] = 1'b0;
    else                merged[2] = bus.upd_c ? bus.alu_flags[2] : ccr_q[2];
    if (taken) begin
      case (bus.jmp_type)
        2'b01:   merged[0] = 1'b0;
        2'b10:   merged[1] = 1'b0;
        2'b11:   merged[2] = 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    top_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CNT_W'(i + 1)) top_entry = stack_q[i];
    end
  end

  assign stk_empty = (cnt_q == '0);
  assign stk_full  = (cnt_q == CNT_W'(DEPTH));
  // Save+restore on an empty stack degenerates to a plain push.
  assign swap_go   = bus.int_save && bus.rti_restore && !stk_empty;
  assign push_go   = bus.int_save && !swap_go && !stk_full;
  assign pop_go    = bus.rti_restore && !bus.int_save && !stk_empty;
  assign wr_idx    = swap_go ? (cnt_q - CNT_W'(1)) : cnt_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign slot_wr[gi] = bus.en && (swap_go || push_go) && (wr_idx == CNT_W'(gi));
  end

  always_comb begin
    ccr_d = ccr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.en) begin
      ccr_d = (bus.rti_restore && !stk_empty) ? top_entry : merged;
      if (push_go) cnt_d = cnt_q + CNT_W'(1);
      if (pop_go)  cnt_d = cnt_q - CNT_W'(1);
      if (bus.int_save && !bus.rti_restore && stk_full) ovf_d = 1'b1;
      if (bus.rti_restore && stk_empty)                 unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      ccr_q <= ccr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_wr[i]) stack_q[i] <= ccr_q;
      end
    end
  end

  assign bus.ccr          = ccr_q;
  assign bus.branch_taken = taken;
  assign bus.stack_count  = cnt_q;
  assign bus.ovf          = ovf_q;
  assign bus.unf          = unf_q;
endmodule
